// File: rtl/shift_register.sv
// shift_register: 4-bit loadable register with one-step left/right shift and left-shift carry flag
module shift_register (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] IN1,
    input  logic       LOAD_ENABLE,
    input  logic [1:0] SHIFT,
    output logic [3:0] OUT,
    output logic       FLAG
);
    logic [3:0] dataReg;
    logic [3:0] data_d;
    logic [3:0] src;
    logic       flag_q;
    logic       flag_d;

    // Operand select, then shift as 5-bit {carry,data}; conflicting 2'b11 falls through to plain load/hold
    always_comb begin
        src = LOAD_ENABLE ? IN1 : dataReg;
        {flag_d, data_d} = (SHIFT == 2'b10) ? {src, 1'b0} :
                           (SHIFT == 2'b01) ? {2'b00, src[3:1]} :
                                              {1'b0, src};
    end

    // State register with synchronous reset overriding every other control
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dataReg <= 4'b0000;
            flag_q  <= 1'b0;
        end else begin
            dataReg <= data_d;
            flag_q  <= flag_d;
        end
    end

    assign OUT  = dataReg;
    assign FLAG = flag_q;
endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: directed self-checking bench for shift_register
module tb_shift_register;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] IN1 = 4'h0;
    logic       LOAD_ENABLE = 1'b0;
    logic [1:0] SHIFT = 2'b00;
    logic [3:0] OUT;
    logic       FLAG;
    int checks = 0;
    int errors = 0;

    shift_register dut (
        .CLK(CLK),
        .RESET(RESET),
        .IN1(IN1),
        .LOAD_ENABLE(LOAD_ENABLE),
        .SHIFT(SHIFT),
        .OUT(OUT),
        .FLAG(FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [4:0] exp);
        checks++;
        assert ({FLAG, OUT} === exp && dut.dataReg === exp[3:0]) else begin
            errors++;
            $error("FAIL %s got FLAG/OUT=%h dataReg=%h want %h", tag, {FLAG, OUT}, dut.dataReg, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic le, input logic [3:0] in, input logic [1:0] sh);
        RESET = rst;
        LOAD_ENABLE = le;
        IN1 = in;
        SHIFT = sh;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [4:0] e;
        @(negedge CLK);
        cyc(1'b1, 1'b1, 4'hF, 2'b10);
        chk("reset", 5'h00);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, i[3:0], 2'b00);
            chk("load", {1'b0, i[3:0]});
        end
        for (int i = 0; i < 16; i++) begin
            e = {1'b0, i[3:0]} << 1;
            cyc(1'b0, 1'b1, i[3:0], 2'b10);
            chk("load_lsh", e);
        end
        cyc(1'b0, 1'b1, 4'b1011, 2'b10);
        chk("lsh_1011", 5'b1_0110);
        for (int i = 0; i < 16; i++) begin
            e = {1'b0, i[3:0]} >> 1;
            cyc(1'b0, 1'b1, i[3:0], 2'b01);
            chk("load_rsh", e);
        end
        cyc(1'b0, 1'b1, 4'b1011, 2'b01);
        chk("rsh_1011", 5'b0_0101);
        cyc(1'b0, 1'b1, 4'b0011, 2'b00);
        chk("cont_load", 5'b0_0011);
        cyc(1'b0, 1'b0, 4'hF, 2'b10);
        chk("cont_lsh1", 5'b0_0110);
        cyc(1'b0, 1'b0, 4'hF, 2'b10);
        chk("cont_lsh2", 5'b0_1100);
        cyc(1'b0, 1'b0, 4'hF, 2'b10);
        chk("cont_lsh3", 5'b1_1000);
        cyc(1'b0, 1'b0, 4'hF, 2'b10);
        chk("cont_lsh4", 5'b1_0000);
        cyc(1'b0, 1'b1, 4'b1001, 2'b11);
        chk("conflict_load", 5'b0_1001);
        cyc(1'b0, 1'b0, 4'h6, 2'b00);
        chk("hold1", 5'b0_1001);
        cyc(1'b0, 1'b0, 4'h6, 2'b00);
        chk("hold2", 5'b0_1001);
        cyc(1'b0, 1'b1, 4'b1100, 2'b10);
        chk("flag_set", 5'b1_1000);
        cyc(1'b0, 1'b0, 4'h3, 2'b11);
        chk("conflict_hold_clr", 5'b0_1000);
        cyc(1'b0, 1'b1, 4'b1111, 2'b00);
        chk("rst_mid_load", 5'b0_1111);
        cyc(1'b0, 1'b0, 4'h0, 2'b01);
        chk("rst_mid_rsh", 5'b0_0111);
        cyc(1'b1, 1'b0, 4'h0, 2'b01);
        chk("rst_mid_reset", 5'b0_0000);
        cyc(1'b0, 1'b1, 4'b0101, 2'b00);
        chk("rst_mid_reload", 5'b0_0101);
        cyc(1'b0, 1'b0, 4'hF, 2'b01);
        chk("cont_rsh1", 5'b0_0010);
        cyc(1'b0, 1'b0, 4'hF, 2'b01);
        chk("cont_rsh2", 5'b0_0001);
        cyc(1'b0, 1'b0, 4'hF, 2'b01);
        chk("cont_rsh3", 5'b0_0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
